sensor_extend: RTL and testbench
================================

# sensor_extend

Upstream request conditioner for the traffic controller's `extension` input. It takes the raw, asynchronous NS-approach vehicle sensor, synchronizes it and debounces it in `tick` units. It then turns a confirmed detection into an extension request that spans exactly one tick interval, so the controller samples it at its next `tick`. Extensions are granted only while NS is green, are capped per green phase, and are spaced by a cooldown. The block sits between the sensor pad and the controller, and shares `clk` and the `tick1s` pulse with both.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flops on `car_sensor`; minimum 2.
- `DEBOUNCE_TICKS`, default 3: consecutive ticks `sensor_s` must stay high before a detection is confirmed; minimum 1.
- `MAX_EXT`, default 2: maximum extensions granted per NS-green phase; minimum 1.
- `COOLDOWN_TICKS`, default 4: ticks after an extension before another request is accepted; minimum 1.
- `clk`, input, 1: system clock.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `tick`, input, 1: one-`clk`-wide pulse from the tick generator.
- `car_sensor`, input, 1: raw asynchronous sensor level.
- `ns_green`, input, 1: NS green lamp from the traffic controller; used as the phase qualifier.
- `extension`, output, 1: registered request to the controller.
- `ext_count`, output, $clog2(MAX_EXT+1): extensions granted in the current NS-green phase.
- `detected`, output, 1: registered debounced sensor level.

## Operation
- **Reset.** Asserting `reset_n` low asynchronously clears all synchronizer flops, counters and outputs. The FSM returns to IDLE. `extension`=0, `ext_count`=0, `detected`=0.
- **Synchronizer.** `SYNC_STAGES` flops produce `sensor_s`.
- **Debounce.**
  - `deb_cnt` clears on any cycle where `sensor_s`=0.
  - Otherwise `deb_cnt` increments on each `tick` and saturates at `DEBOUNCE_TICKS`.
  - `detected` = (`deb_cnt`==`DEBOUNCE_TICKS`), registered.
  - `det_rise` = `detected` 0→1, a one-cycle internal pulse.
- **FSM states:** IDLE, PEND, EXTEND, COOL.
  - **IDLE:** if `det_rise` and `ns_green`, go to PEND. A `det_rise` while `ns_green`=0 is discarded.
  - **PEND:** on `tick`:
    - if `ext_count`==`MAX_EXT`, go to IDLE (request dropped);
    - otherwise go to EXTEND and increment `ext_count`.
  - **EXTEND:** `extension`=1. On the next `tick`, go to COOL and clear `cool_cnt`.
  - **COOL:** `cool_cnt` increments on `tick`. When it reaches `COOLDOWN_TICKS`, go to IDLE. A `det_rise` during COOL is ignored; a vehicle that stays present does not re-trigger until the sensor drops and re-debounces.
- **Phase end.** Any cycle with `ns_green`=0 forces the FSM to IDLE from any state and clears `ext_count` (`ns_green` is checked with priority over `tick`).
- **Arithmetic.**
  - `deb_cnt` width is $clog2(DEBOUNCE_TICKS+1).
  - `cool_cnt` width is $clog2(COOLDOWN_TICKS+1).
  - All counters saturate and never wrap.
  - `ext_count` never exceeds `MAX_EXT`.

## Timing
- **Sensor latency.**
  - `car_sensor` rising reaches `sensor_s` after `SYNC_STAGES` clks.
  - `detected` rises 1 clk after the `DEBOUNCE_TICKS`-th tick that sees `sensor_s`=1.
- **Extension timing.**
  - `det_rise`→PEND takes 1 clk.
  - `extension` rises 1 clk after the first subsequent `tick` cycle.
  - It stays high through the following `tick` cycle inclusive, so the controller samples 1 on that tick.
  - It falls 1 clk after that tick.
  - High width = one tick period.
- **Cooldown.** The earliest next `extension` rise is `COOLDOWN_TICKS`+1 ticks after the previous fall.
- **`ns_green` fall.** When `ns_green` falls during EXTEND, `extension` drops 1 clk later and `ext_count` reads 0 on that same clk.
- **Simultaneous events.**
  - `det_rise` and `tick` in the same cycle in IDLE: enter PEND only; that tick is not used for the grant.
  - `tick` in the same cycle `ns_green` falls: the `ns_green` fall wins.
- **Reset mid-operation.** `reset_n` low during EXTEND drops `extension` immediately (async). After `reset_n` deasserts, the block restarts in IDLE; the sensor must re-debounce.

## Test plan
- **Basic extension.** After reset, `ns_green`=1, tick every 10 clks, `car_sensor`=1 held.
  - `detected` rises after the 3rd tick.
  - `extension` is high for exactly 10 clks, covering one tick cycle.
  - `ext_count`=1.
- **Glitch rejection.** `car_sensor` high for 2 ticks, low for 1 clk, high for 2 ticks → `detected` stays 0 and `extension` stays 0.
- **Cap and cooldown.** Toggle the sensor to re-debounce repeatedly while green (`MAX_EXT`=2, `COOLDOWN_TICKS`=4).
  - Two extensions, ≥5 ticks apart.
  - The third request is dropped; `ext_count` holds 2.
- **Phase gating.**
  - Detection while `ns_green`=0 → no extension.
  - Drop `ns_green` during EXTEND → `extension`=0 and `ext_count`=0 one clk later.
- **Async reset.** Pulse `reset_n` low mid-EXTEND, off the clock edge → `extension`=0 immediately, and all outputs stay 0 until a fresh 3-tick debounce completes.

Source files
------------

// File: rtl/sensor_extend.sv
// sensor_extend: conditions the raw NS vehicle sensor into a
// one-tick-wide extension request for the traffic controller.
module sensor_extend #(
    parameter int SYNC_STAGES    = 2,
    parameter int DEBOUNCE_TICKS = 3,
    parameter int MAX_EXT        = 2,
    parameter int COOLDOWN_TICKS = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         tick,
    input  logic                         car_sensor,
    input  logic                         ns_green,
    output logic                         extension,
    output logic [$clog2(MAX_EXT+1)-1:0] ext_count,
    output logic                         detected
);

    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam int CW = $clog2(COOLDOWN_TICKS + 1);
    localparam int EW = $clog2(MAX_EXT + 1);

    localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_TICKS);
    localparam logic [CW-1:0] COOL_MAX = CW'(COOLDOWN_TICKS);
    localparam logic [EW-1:0] EXT_MAX  = EW'(MAX_EXT);

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        EXTEND,
        COOL
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sensor_s;
    logic [DW-1:0]          deb_cnt;
    logic [DW-1:0]          deb_nxt;
    logic                   detected_q;
    logic                   det_rise;
    logic [CW-1:0]          cool_cnt;

    assign sensor_s = sync_q[SYNC_STAGES-1];
    assign det_rise = detected & ~detected_q;

    // Shift the raw sensor through the synchronizer chain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], car_sensor};
        end
    end

    // Next debounce count: clear on low, count ticks while high, saturate
    always_comb begin
        deb_nxt = deb_cnt;
        if (!sensor_s) begin
            deb_nxt = '0;
        end else if (tick && (deb_cnt != DEB_MAX)) begin
            deb_nxt = deb_cnt + DW'(1);
        end
    end

    // Debounce counter, registered detection level and its delayed copy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_cnt    <= '0;
            detected   <= 1'b0;
            detected_q <= 1'b0;
        end else begin
            deb_cnt    <= deb_nxt;
            detected   <= (deb_nxt == DEB_MAX);
            detected_q <= detected;
        end
    end

    // Request FSM: green-qualified, capped per phase, spaced by cooldown
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ext_count <= '0;
            extension <= 1'b0;
            cool_cnt  <= '0;
        end else if (!ns_green) begin
            state     <= IDLE;
            ext_count <= '0;
            extension <= 1'b0;
            cool_cnt  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (det_rise) begin
                        state <= PEND;
                    end
                end
                PEND: begin
                    if (tick) begin
                        if (ext_count == EXT_MAX) begin
                            state <= IDLE;
                        end else begin
                            state     <= EXTEND;
                            ext_count <= ext_count + EW'(1);
                            extension <= 1'b1;
                        end
                    end
                end
                EXTEND: begin
                    if (tick) begin
                        state     <= COOL;
                        cool_cnt  <= '0;
                        extension <= 1'b0;
                    end
                end
                COOL: begin
                    if (tick) begin
                        if (cool_cnt != COOL_MAX) begin
                            cool_cnt <= cool_cnt + CW'(1);
                        end
                        if (cool_cnt >= COOL_MAX - CW'(1)) begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_extend.sv
// tb_sensor_extend: directed and randomized checks of sensor_extend
// against a behavioural model of the request rules.
module tb_sensor_extend;

    localparam int S     = 2;
    localparam int DEB   = 3;
    localparam int MAXE  = 2;
    localparam int COOLT = 4;
    localparam int EW    = $clog2(MAXE + 1);

    logic          clk = 1'b0;
    logic          reset_n;
    logic          tick;
    logic          car_sensor;
    logic          ns_green;
    logic          extension;
    logic          detected;
    logic [EW-1:0] ext_count;

    sensor_extend #(
        .SYNC_STAGES   (S),
        .DEBOUNCE_TICKS(DEB),
        .MAX_EXT       (MAXE),
        .COOLDOWN_TICKS(COOLT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .tick      (tick),
        .car_sensor(car_sensor),
        .ns_green  (ns_green),
        .extension (extension),
        .ext_count (ext_count),
        .detected  (detected)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;
    bit rnd_mode = 1'b0;

    int n_rise   = 0;
    int fall_cyc = 0;
    int gap      = 0;
    bit ext_prev = 1'b0;

    // behavioural model state
    bit m_q[$];
    bit m_s;
    bit m_rise;
    int m_run;
    bit m_det;
    bit m_det_d;
    bit m_want;
    bit m_ext;
    int m_cool;
    int m_cnt;

    // Model: delay line, tick-run debounce, then request rules
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_q.delete();
            for (int i = 0; i < S; i++) m_q.push_back(1'b0);
            m_run   = 0;
            m_det   = 1'b0;
            m_det_d = 1'b0;
            m_want  = 1'b0;
            m_ext   = 1'b0;
            m_cool  = 0;
            m_cnt   = 0;
        end else begin
            m_s = m_q.pop_front();
            m_q.push_back(car_sensor);
            m_rise = m_det && !m_det_d;
            if (!ns_green) begin
                m_want = 1'b0;
                m_ext  = 1'b0;
                m_cool = 0;
                m_cnt  = 0;
            end else if (m_ext) begin
                if (tick) begin
                    m_ext  = 1'b0;
                    m_cool = COOLT;
                end
            end else if (m_cool > 0) begin
                if (tick) m_cool--;
            end else if (m_want) begin
                if (tick) begin
                    m_want = 1'b0;
                    if (m_cnt < MAXE) begin
                        m_cnt++;
                        m_ext = 1'b1;
                    end
                end
            end else if (m_rise) begin
                m_want = 1'b1;
            end
            m_det_d = m_det;
            if (!m_s) m_run = 0;
            else if (tick && m_run < DEB) m_run++;
            m_det = (m_run == DEB);
        end
    end

    // Compare DUT outputs with the model every cycle
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (extension !== m_ext) begin
                failures++;
                $display("FAIL extension cyc=%0d got=%b exp=%b",
                         cyc, extension, m_ext);
            end
            checks++;
            if (detected !== m_det) begin
                failures++;
                $display("FAIL detected cyc=%0d got=%b exp=%b",
                         cyc, detected, m_det);
            end
            checks++;
            if (ext_count !== EW'(m_cnt)) begin
                failures++;
                $display("FAIL ext_count cyc=%0d got=%0d exp=%0d",
                         cyc, ext_count, m_cnt);
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
        end
    endtask

    task automatic step(input bit s, input bit g);
        car_sensor = s;
        ns_green   = g;
        tick = rnd_mode ? ($urandom_range(0, 3) == 0) : (cyc % 10 == 9);
        @(negedge clk);
        cyc++;
        if (extension === 1'b1 && !ext_prev) begin
            n_rise++;
            gap = cyc - fall_cyc;
        end
        if (extension !== 1'b1 && ext_prev) fall_cyc = cyc;
        ext_prev = (extension === 1'b1);
    endtask

    task automatic reset_pulse();
        #3 reset_n = 1'b0;
        #1;
        chk("rst_ext_now", int'(extension), 0);
        chk("rst_cnt_now", int'(ext_count), 0);
        chk("rst_det_now", int'(detected), 0);
        @(negedge clk);
        cyc++;
        ext_prev = 1'b0;
        #3 reset_n = 1'b1;
    endtask

    task automatic wait_ext(input string name);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            step(1'b1, 1'b1);
            if (extension === 1'b1) found = 1'b1;
        end
        chk(name, int'(found), 1);
    endtask

    bit det_seen;
    bit ext_seen;
    int det_at;
    int ext_at;
    int ext_hi;
    int nt;
    bit bad;
    bit rs;
    bit rg;

    initial begin
        reset_n    = 1'b0;
        tick       = 1'b0;
        car_sensor = 1'b0;
        ns_green   = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_ext", int'(extension), 0);
        chk("reset_cnt", int'(ext_count), 0);
        chk("reset_det", int'(detected), 0);
        reset_n = 1'b1;
        cyc     = 0;

        // glitch: 2 ticks high, 1 clk low, 2 ticks high
        det_seen = 1'b0;
        ext_seen = 1'b0;
        n_rise   = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1);
            det_seen |= (detected === 1'b1);
        end
        step(1'b0, 1'b1);
        det_seen |= (detected === 1'b1);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1);
            det_seen |= (detected === 1'b1);
            ext_seen |= (extension === 1'b1);
        end
        while (cyc % 10 != 0) step(1'b0, 1'b1);
        chk("glitch_det", int'(det_seen), 0);
        chk("glitch_ext", int'(ext_seen), 0);

        // basic extension with sensor held
        det_at = -1;
        ext_at = -1;
        ext_hi = 0;
        n_rise = 0;
        for (int i = 0; i < 60; i++) begin
            step(1'b1, 1'b1);
            if (detected === 1'b1 && det_at < 0) det_at = i;
            if (extension === 1'b1) begin
                ext_hi++;
                if (ext_at < 0) ext_at = i;
            end
        end
        chk("basic_det_at", det_at, 29);
        chk("basic_ext_at", ext_at, 39);
        chk("basic_ext_width", ext_hi, 10);
        chk("basic_cnt", int'(ext_count), 1);

        // cap and cooldown: repeated re-debounce while green
        for (int r = 0; r < 4; r++) begin
            repeat (3) step(1'b0, 1'b1);
            repeat (47) step(1'b1, 1'b1);
        end
        chk("cap_rises", n_rise, 2);
        chk("cool_gap", gap, 50);
        chk("cap_cnt", int'(ext_count), 2);

        // phase gating: detection while red, then green drop in EXTEND
        step(1'b0, 1'b0);
        chk("red_cnt_clr", int'(ext_count), 0);
        n_rise = 0;
        repeat (2) step(1'b0, 1'b0);
        repeat (47) step(1'b1, 1'b0);
        chk("red_det", int'(detected), 1);
        chk("red_no_ext", n_rise, 0);
        repeat (3) step(1'b0, 1'b1);
        wait_ext("gate_ext_seen");
        repeat (2) step(1'b1, 1'b1);
        chk("gate_ext_hold", int'(extension), 1);
        step(1'b1, 1'b0);
        chk("gate_ext_drop", int'(extension), 0);
        chk("gate_cnt_drop", int'(ext_count), 0);

        // async reset mid-EXTEND, then a fresh debounce
        repeat (3) step(1'b0, 1'b1);
        wait_ext("rst_ext_seen");
        step(1'b1, 1'b1);
        reset_pulse();
        nt  = 0;
        bad = 1'b0;
        for (int j = 0; j < 60 && nt < 3; j++) begin
            step(1'b1, 1'b1);
            if (tick && j >= 2) nt++;
            if (nt < 3 && (detected !== 1'b0 || extension !== 1'b0 ||
                           ext_count !== '0)) bad = 1'b1;
        end
        chk("rst_quiet", int'(bad), 0);
        chk("rst_redeb", int'(detected), 1);

        // randomized traffic against the model
        rnd_mode = 1'b1;
        rs = 1'b0;
        rg = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 19) == 0) rs = ~rs;
            if ($urandom_range(0, 149) == 0) rg = ~rg;
            step(rs, rg);
            if (n == 1500) reset_pulse();
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
